axi_rd_arbiter: RTL and testbench

AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

---
 rtl/axi_rd_arbiter_pkg.sv | 37 +++
 rtl/axi_rd_arbiter_decoder.sv | 27 ++
 rtl/axi_rd_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rd_arbiter_pkg.sv
// Shared definitions for the two-master AXI read arbiter: field widths,
// AXI response codes, FSM state encoding and the reserved-slave test.
// Optional feature macro: AXI_DECERR_EN (adds the ERR state).
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif

package axi_rd_arbiter_pkg;

  localparam int AXI_LEN_WIDTH      = 8;
  localparam int AXI_RESP_WIDTH     = 2;
  localparam int AXI_SLAVE_NO_WIDTH = 3;

  localparam logic [AXI_RESP_WIDTH-1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [AXI_RESP_WIDTH-1:0] AXI_RESP_DECERR = 2'b11;

`ifdef AXI_DECERR_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_ERR  = 2'd3
  } arb_state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } arb_state_t;
`endif

  // Slaves 3 and 5 are holes in the address map; they answer with DECERR.
  function automatic logic is_reserved(input logic [AXI_SLAVE_NO_WIDTH-1:0] slave_no);
    return (slave_no == 3'd3) || (slave_no == 3'd5);
  endfunction

endpackage

// File: rtl/axi_rd_arbiter_decoder.sv
// Address map decoder: turns the top address byte into a slave number.
//   nibble < 4 -> 0, nibble 4 -> 1 or 2 (split on addr[27:24] < 4),
//   5/6 -> 3, 7 -> 4, >= 8 -> 5.
module axi_decoder
  import axi_rd_arbiter_pkg::*;
(
  input  logic [7:0]                    addr_top,
  output logic [AXI_SLAVE_NO_WIDTH-1:0] slave_no
);

  logic [3:0] hi_nib;
  logic [3:0] lo_nib;

  assign hi_nib = addr_top[7:4];
  assign lo_nib = addr_top[3:0];

  // Priority chain over the top nibble of the address.
  always_comb begin
    slave_no = 3'd5;
    if (hi_nib < 4'd4)       slave_no = 3'd0;
    else if (hi_nib == 4'd4) slave_no = (lo_nib < 4'd4) ? 3'd1 : 3'd2;
    else if (hi_nib <= 4'd6) slave_no = 3'd3;
    else if (hi_nib == 4'd7) slave_no = 3'd4;
    else                     slave_no = 3'd5;
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Two-master round-robin AXI read arbiter onto one shared slave port.
// One transaction in flight; FSM IDLE -> ADDR -> DATA (-> ERR with macro).
// Optional feature macro: AXI_DECERR_EN -- reserved slaves (3, 5) are
// answered locally with DECERR beats instead of being forwarded.
//
// Handshake rule on every channel: a transfer happens on the rising ACLK
// edge where valid and ready are both 1; a valid source holds its payload
// stable until that edge, and ready never depends on a future valid.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif

module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = `AXI_ADDR_WIDTH,
  parameter int AXI_DATA_WIDTH = 32
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  // master 0
  input  logic                          m0_arvalid,
  output logic                          m0_arready,
  input  logic [AXI_ADDR_WIDTH-1:0]     m0_araddr,
  input  logic [AXI_LEN_WIDTH-1:0]      m0_arlen,
  output logic                          m0_rvalid,
  input  logic                          m0_rready,
  output logic [AXI_DATA_WIDTH-1:0]     m0_rdata,
  output logic [AXI_RESP_WIDTH-1:0]     m0_rresp,
  output logic                          m0_rlast,
  // master 1
  input  logic                          m1_arvalid,
  output logic                          m1_arready,
  input  logic [AXI_ADDR_WIDTH-1:0]     m1_araddr,
  input  logic [AXI_LEN_WIDTH-1:0]      m1_arlen,
  output logic                          m1_rvalid,
  input  logic                          m1_rready,
  output logic [AXI_DATA_WIDTH-1:0]     m1_rdata,
  output logic [AXI_RESP_WIDTH-1:0]     m1_rresp,
  output logic                          m1_rlast,
  // shared slave address channel
  output logic                          s_arvalid,
  input  logic                          s_arready,
  output logic [AXI_ADDR_WIDTH-1:0]     s_araddr,
  output logic [AXI_LEN_WIDTH-1:0]      s_arlen,
  output logic [AXI_SLAVE_NO_WIDTH-1:0] s_slave_no,
  // shared slave read channel
  input  logic                          s_rvalid,
  output logic                          s_rready,
  input  logic [AXI_DATA_WIDTH-1:0]     s_rdata,
  input  logic [AXI_RESP_WIDTH-1:0]     s_rresp,
  input  logic                          s_rlast,
  // debug view of the FSM
  output logic [1:0]                    dbg_state
);

  arb_state_t                    state;
  logic                          grant;       // 0 = M0 owns the transaction, 1 = M1
  logic                          last_grant;  // most recent winner, for round-robin
  logic                          win;
  logic [AXI_ADDR_WIDTH-1:0]     win_addr;
  logic [AXI_LEN_WIDTH-1:0]      win_len;
  logic [AXI_SLAVE_NO_WIDTH-1:0] dec_slave_no;
  logic                          granted_rready;
`ifdef AXI_DECERR_EN
  logic [AXI_LEN_WIDTH-1:0]      err_cnt;
  logic                          err_last;
  assign err_last = (err_cnt == s_arlen);
`endif

  assign dbg_state      = state;
  assign granted_rready = grant ? m1_rready : m0_rready;

  // Round-robin pick: on a tie the master that did not win last time wins.
  always_comb begin
    win = 1'b0;
    if (m0_arvalid && m1_arvalid) win = ~last_grant;
    else if (m1_arvalid)          win = 1'b1;
  end

  assign win_addr = win ? m1_araddr : m0_araddr;
  assign win_len  = win ? m1_arlen  : m0_arlen;

  axi_decoder u_decoder (
    .addr_top (win_addr[AXI_ADDR_WIDTH-1 -: 8]),
    .slave_no (dec_slave_no)
  );

  // Transaction FSM with registered address-side outputs.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state      <= ST_IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      m0_arready <= 1'b0;
      m1_arready <= 1'b0;
      s_arvalid  <= 1'b0;
      s_araddr   <= '0;
      s_arlen    <= '0;
      s_slave_no <= '0;
`ifdef AXI_DECERR_EN
      err_cnt    <= '0;
`endif
    end else begin
      m0_arready <= 1'b0;
      m1_arready <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (m0_arvalid || m1_arvalid) begin
            grant      <= win;
            last_grant <= win;
            m0_arready <= ~win;
            m1_arready <= win;
            s_araddr   <= win_addr;
            s_arlen    <= win_len;
            s_slave_no <= dec_slave_no;
`ifdef AXI_DECERR_EN
            if (is_reserved(dec_slave_no)) begin
              state   <= ST_ERR;
              err_cnt <= '0;
            end else begin
              state <= ST_ADDR;
            end
`else
            state <= ST_ADDR;
`endif
          end
        end
        ST_ADDR: begin
          // First ADDR cycle raises s_arvalid; it then holds until accepted.
          if (!s_arvalid) begin
            s_arvalid <= 1'b1;
          end else if (s_arready) begin
            s_arvalid <= 1'b0;
            state     <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (s_rvalid && s_rready && s_rlast) state <= ST_IDLE;
        end
`ifdef AXI_DECERR_EN
        ST_ERR: begin
          if (granted_rready) begin
            if (err_last) state <= ST_IDLE;
            else          err_cnt <= err_cnt + 8'd1;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Read-data routing to the granted master; the other master sees rvalid=0.
  always_comb begin
    m0_rvalid = 1'b0;
    m1_rvalid = 1'b0;
    m0_rdata  = s_rdata;
    m1_rdata  = s_rdata;
    m0_rresp  = s_rresp;
    m1_rresp  = s_rresp;
    m0_rlast  = s_rlast;
    m1_rlast  = s_rlast;
    s_rready  = 1'b0;
    if (state == ST_DATA) begin
      s_rready = granted_rready;
      if (grant) m1_rvalid = s_rvalid;
      else       m0_rvalid = s_rvalid;
    end
`ifdef AXI_DECERR_EN
    if (state == ST_ERR) begin
      if (grant) begin
        m1_rvalid = 1'b1;
        m1_rdata  = '0;
        m1_rresp  = AXI_RESP_DECERR;
        m1_rlast  = err_last;
      end else begin
        m0_rvalid = 1'b1;
        m0_rdata  = '0;
        m0_rresp  = AXI_RESP_DECERR;
        m0_rlast  = err_last;
      end
    end
`endif
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter (default build or AXI_DECERR_EN).
module tb_axi_rd_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW + 3;   // {rresp, rlast, rdata}
  localparam int RW = AW + 11;  // {slave_no, arlen, araddr}

  logic          ACLK = 1'b0;
  logic          ARESET;
  logic          m0_arvalid, m0_arready, m0_rvalid, m0_rready, m0_rlast;
  logic [AW-1:0] m0_araddr;
  logic [7:0]    m0_arlen;
  logic [DW-1:0] m0_rdata;
  logic [1:0]    m0_rresp;
  logic          m1_arvalid, m1_arready, m1_rvalid, m1_rready, m1_rlast;
  logic [AW-1:0] m1_araddr;
  logic [7:0]    m1_arlen;
  logic [DW-1:0] m1_rdata;
  logic [1:0]    m1_rresp;
  logic          s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
  logic [AW-1:0] s_araddr;
  logic [7:0]    s_arlen;
  logic [2:0]    s_slave_no;
  logic [DW-1:0] s_rdata;
  logic [1:0]    s_rresp;
  logic [1:0]    dbg_state;

  int total = 0;
  int bad = 0;
  int timeouts = 0;
  int cyc = 0;
  int ar_rises = 0;
  int ar_hi = 0;
  int ar_unstable = 0;
  int m1_vcnt = 0;
  int arready_cyc = 0;
  int arvalid_cyc = 0;
  bit m0_toggle = 1'b0;

  logic [BW-1:0] exp0_q[$];
  logic [BW-1:0] exp1_q[$];
  logic [RW-1:0] exp_ar_q[$];
  int            grant_log[$];

  logic          ar_prev_valid = 1'b0;
  logic          ar_prev_hs = 1'b0;
  logic [RW-1:0] ar_prev = '0;

  axi_rd_arbiter #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr),
    .m0_arlen(m0_arlen), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rlast(m0_rlast),
    .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr),
    .m1_arlen(m1_arlen), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rlast(m1_rlast),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_arlen(s_arlen), .s_slave_no(s_slave_no),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
    .s_rresp(s_rresp), .s_rlast(s_rlast),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 ACLK = ~ACLK;

  initial forever begin
    @(posedge ACLK);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // master 0 ready toggler for backpressure
  initial forever begin
    @(posedge ACLK);
    #1;
    if (m0_toggle) m0_rready = ~m0_rready;
  end

  // ---------------- monitor + scoreboard ----------------
  initial forever begin
    logic [BW-1:0] g;
    logic [BW-1:0] e;
    logic [RW-1:0] ga;
    logic [RW-1:0] ea;
    @(negedge ACLK);
    if (m0_rvalid && m0_rready) begin
      g = {m0_rresp, m0_rlast, m0_rdata};
      total++;
      if (exp0_q.size() == 0) begin
        bad++; $display("FAIL m0_beat unexpected got=%h", g);
      end else begin
        e = exp0_q.pop_front();
        if (g !== e) begin bad++; $display("FAIL m0_beat got=%h exp=%h", g, e); end
      end
    end
    if (m1_rvalid && m1_rready) begin
      g = {m1_rresp, m1_rlast, m1_rdata};
      total++;
      if (exp1_q.size() == 0) begin
        bad++; $display("FAIL m1_beat unexpected got=%h", g);
      end else begin
        e = exp1_q.pop_front();
        if (g !== e) begin bad++; $display("FAIL m1_beat got=%h exp=%h", g, e); end
      end
    end
    if (s_arvalid && s_arready) begin
      ga = {s_slave_no, s_arlen, s_araddr};
      total++;
      if (exp_ar_q.size() == 0) begin
        bad++; $display("FAIL ar_xfer unexpected got=%h", ga);
      end else begin
        ea = exp_ar_q.pop_front();
        if (ga !== ea) begin bad++; $display("FAIL ar_xfer got=%h exp=%h", ga, ea); end
      end
    end
    if (m1_rvalid) m1_vcnt++;
    if (m0_arready) begin grant_log.push_back(0); arready_cyc = cyc; end
    if (m1_arready) begin grant_log.push_back(1); arready_cyc = cyc; end
    if (s_arvalid && !ar_prev_valid) begin ar_rises++; arvalid_cyc = cyc; end
    if (s_arvalid) ar_hi++;
    if (s_arvalid && ar_prev_valid && !ar_prev_hs &&
        ({s_slave_no, s_arlen, s_araddr} != ar_prev)) ar_unstable++;
    ar_prev_valid = s_arvalid;
    ar_prev_hs    = s_arvalid && s_arready;
    ar_prev       = {s_slave_no, s_arlen, s_araddr};
  end

  // ---------------- driver tasks ----------------
  task automatic master_req(input int idx, input logic [AW-1:0] addr, input logic [7:0] len);
    int   t;
    logic hs;
    if (idx == 0) begin m0_arvalid = 1'b1; m0_araddr = addr; m0_arlen = len; end
    else          begin m1_arvalid = 1'b1; m1_araddr = addr; m1_arlen = len; end
    t = 0;
    hs = 1'b0;
    while (!hs && t < 200) begin
      @(negedge ACLK);
      hs = (idx == 0) ? m0_arready : m1_arready;
      @(posedge ACLK);
      #1;
      t++;
    end
    if (!hs) timeouts++;
    if (idx == 0) m0_arvalid = 1'b0;
    else          m1_arvalid = 1'b0;
  endtask

  task automatic slave_serve(input int stall, input int nbeats, input logic [DW-1:0] base);
    int   t;
    logic hs;
    t = 0;
    while (!s_arvalid && t < 200) begin
      @(posedge ACLK);
      #1;
      t++;
    end
    if (!s_arvalid) begin
      timeouts++;
      return;
    end
    repeat (stall) begin
      @(posedge ACLK);
      #1;
    end
    s_arready = 1'b1;
    @(posedge ACLK);
    #1;
    s_arready = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      s_rvalid = 1'b1;
      s_rdata  = base + DW'(i);
      s_rresp  = 2'b00;
      s_rlast  = (i == nbeats - 1);
      hs = 1'b0;
      t = 0;
      while (!hs && t < 200) begin
        @(negedge ACLK);
        hs = s_rready;
        @(posedge ACLK);
        #1;
        t++;
      end
      if (!hs) timeouts++;
    end
    s_rvalid = 1'b0;
    s_rlast  = 1'b0;
  endtask

  task automatic push_beats(input int idx, input int nbeats, input logic [DW-1:0] base);
    logic [BW-1:0] w;
    for (int i = 0; i < nbeats; i++) begin
      w = {2'b00, (i == nbeats - 1), base + DW'(i)};
      if (idx == 0) exp0_q.push_back(w);
      else          exp1_q.push_back(w);
    end
  endtask

  task automatic apply_reset();
    ARESET = 1'b1;
    repeat (2) @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    @(posedge ACLK);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    ARESET = 1'b1;
    m0_arvalid = 1'b1;
    repeat (3) @(posedge ACLK);
    #1;
    total++; if (m0_arready !== 1'b0) begin bad++; $display("FAIL rst_m0_arready got=%b exp=0", m0_arready); end
    total++; if (m1_arready !== 1'b0) begin bad++; $display("FAIL rst_m1_arready got=%b exp=0", m1_arready); end
    total++; if (s_arvalid !== 1'b0) begin bad++; $display("FAIL rst_s_arvalid got=%b exp=0", s_arvalid); end
    total++; if (s_rready !== 1'b0) begin bad++; $display("FAIL rst_s_rready got=%b exp=0", s_rready); end
    total++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin bad++; $display("FAIL rst_rvalid got=%b exp=00", {m0_rvalid, m1_rvalid}); end
    total++; if (s_araddr !== '0) begin bad++; $display("FAIL rst_s_araddr got=%h exp=0", s_araddr); end
    total++; if (s_arlen !== 8'd0) begin bad++; $display("FAIL rst_s_arlen got=%h exp=0", s_arlen); end
    total++; if (s_slave_no !== 3'd0) begin bad++; $display("FAIL rst_s_slave_no got=%0d exp=0", s_slave_no); end
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", dbg_state); end
    m0_arvalid = 1'b0;
    ARESET = 1'b0;
    repeat (2) @(posedge ACLK);
    #1;
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL idle_no_req_state got=%0d exp=0", dbg_state); end
  endtask

  task automatic test_single_m0();
    int req_cyc;
    int m1v0;
    m1v0 = m1_vcnt;
    exp_ar_q.push_back({3'd0, 8'd3, 32'h0000_1000});
    push_beats(0, 4, 32'hA000_0000);
    req_cyc = cyc;
    fork
      master_req(0, 32'h0000_1000, 8'd3);
      slave_serve(0, 4, 32'hA000_0000);
    join
    repeat (2) @(posedge ACLK);
    #1;
    total++; if (arready_cyc !== req_cyc + 1) begin bad++; $display("FAIL lat_arready got=%0d exp=%0d", arready_cyc, req_cyc + 1); end
    total++; if (arvalid_cyc !== req_cyc + 2) begin bad++; $display("FAIL lat_s_arvalid got=%0d exp=%0d", arvalid_cyc, req_cyc + 2); end
    total++; if (exp0_q.size() != 0) begin bad++; $display("FAIL single_m0_beats left=%0d exp=0", exp0_q.size()); end
    total++; if (exp_ar_q.size() != 0) begin bad++; $display("FAIL single_ar left=%0d exp=0", exp_ar_q.size()); end
    total++; if (m1_vcnt != m1v0) begin bad++; $display("FAIL single_m1_rvalid got=%0d exp=%0d", m1_vcnt, m1v0); end
    total++; if (timeouts != 0) begin bad++; $display("FAIL single_timeout got=%0d exp=0", timeouts); end
  endtask

  task automatic test_round_robin();
    apply_reset();
    grant_log.delete();
    exp_ar_q.push_back({3'd2, 8'd1, 32'h4400_0000});
    exp_ar_q.push_back({3'd4, 8'd2, 32'h7000_0010});
    push_beats(0, 2, 32'hB000_0000);
    push_beats(1, 3, 32'hC000_0000);
    fork
      master_req(0, 32'h4400_0000, 8'd1);
      master_req(1, 32'h7000_0010, 8'd2);
      begin
        slave_serve(0, 2, 32'hB000_0000);
        slave_serve(0, 3, 32'hC000_0000);
      end
    join
    exp_ar_q.push_back({3'd0, 8'd0, 32'h0000_0040});
    exp_ar_q.push_back({3'd1, 8'd0, 32'h4100_0000});
    push_beats(0, 1, 32'hB100_0000);
    push_beats(1, 1, 32'hC100_0000);
    fork
      master_req(0, 32'h0000_0040, 8'd0);
      master_req(1, 32'h4100_0000, 8'd0);
      begin
        slave_serve(0, 1, 32'hB100_0000);
        slave_serve(0, 1, 32'hC100_0000);
      end
    join
    repeat (2) @(posedge ACLK);
    #1;
    total++;
    if (grant_log.size() != 4) begin
      bad++; $display("FAIL rr_grants count got=%0d exp=4", grant_log.size());
    end else if (grant_log[0] != 0 || grant_log[1] != 1 || grant_log[2] != 0 || grant_log[3] != 1) begin
      bad++; $display("FAIL rr_order got=%0d%0d%0d%0d exp=0101", grant_log[0], grant_log[1], grant_log[2], grant_log[3]);
    end
    total++; if (exp0_q.size() + exp1_q.size() != 0) begin bad++; $display("FAIL rr_beats left=%0d exp=0", exp0_q.size() + exp1_q.size()); end
    total++; if (exp_ar_q.size() != 0) begin bad++; $display("FAIL rr_ar left=%0d exp=0", exp_ar_q.size()); end
    total++; if (timeouts != 0) begin bad++; $display("FAIL rr_timeout got=%0d exp=0", timeouts); end
  endtask

  task automatic test_backpressure();
    int hi0;
    int unst0;
    hi0 = ar_hi;
    unst0 = ar_unstable;
    exp_ar_q.push_back({3'd0, 8'd5, 32'h0000_2000});
    push_beats(0, 6, 32'hD000_0000);
    m0_toggle = 1'b1;
    fork
      master_req(0, 32'h0000_2000, 8'd5);
      slave_serve(5, 6, 32'hD000_0000);
    join
    m0_toggle = 1'b0;
    @(posedge ACLK);
    #1;
    m0_rready = 1'b1;
    @(posedge ACLK);
    #1;
    total++; if (ar_hi - hi0 != 6) begin bad++; $display("FAIL bp_arvalid_cycles got=%0d exp=6", ar_hi - hi0); end
    total++; if (ar_unstable != unst0) begin bad++; $display("FAIL bp_ar_stable changes=%0d exp=0", ar_unstable - unst0); end
    total++; if (exp0_q.size() != 0) begin bad++; $display("FAIL bp_beats left=%0d exp=0", exp0_q.size()); end
    total++; if (timeouts != 0) begin bad++; $display("FAIL bp_timeout got=%0d exp=0", timeouts); end
  endtask

  task automatic test_decerr();
    int rises0;
    rises0 = ar_rises;
`ifdef AXI_DECERR_EN
    exp1_q.push_back({2'b11, 1'b0, 32'h0});
    exp1_q.push_back({2'b11, 1'b1, 32'h0});
    master_req(1, 32'h9000_0000, 8'd1);
    for (int t = 0; t < 50 && exp1_q.size() != 0; t++) begin
      @(posedge ACLK);
      #1;
    end
    @(posedge ACLK);
    #1;
    total++; if (ar_rises != rises0) begin bad++; $display("FAIL decerr_s_arvalid rises=%0d exp=0", ar_rises - rises0); end
`else
    exp_ar_q.push_back({3'd5, 8'd1, 32'h9000_0000});
    push_beats(1, 2, 32'hE000_0000);
    fork
      master_req(1, 32'h9000_0000, 8'd1);
      slave_serve(0, 2, 32'hE000_0000);
    join
    @(posedge ACLK);
    #1;
    total++; if (ar_rises != rises0 + 1) begin bad++; $display("FAIL fwd_s_arvalid rises=%0d exp=1", ar_rises - rises0); end
    total++; if (exp_ar_q.size() != 0) begin bad++; $display("FAIL fwd_ar left=%0d exp=0", exp_ar_q.size()); end
`endif
    total++; if (exp1_q.size() != 0) begin bad++; $display("FAIL slave5_beats left=%0d exp=0", exp1_q.size()); end
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL slave5_end_state got=%0d exp=0", dbg_state); end
  endtask

  task automatic test_reset_mid();
    exp_ar_q.push_back({3'd0, 8'd3, 32'h0000_0100});
    exp0_q.push_back({2'b00, 1'b0, 32'hF000_0000});
    fork
      master_req(0, 32'h0000_0100, 8'd3);
      begin
        for (int t = 0; t < 50 && !s_arvalid; t++) begin
          @(posedge ACLK);
          #1;
        end
        s_arready = 1'b1;
        @(posedge ACLK);
        #1;
        s_arready = 1'b0;
        s_rvalid = 1'b1;
        s_rdata  = 32'hF000_0000;
        s_rlast  = 1'b0;
        @(posedge ACLK);
        #1;
        s_rdata = 32'hF000_0001;
        #2;
        ARESET = 1'b1;
        #1;
      end
    join
    total++; if (m0_rvalid !== 1'b0) begin bad++; $display("FAIL midrst_m0_rvalid got=%b exp=0", m0_rvalid); end
    total++; if (s_rready !== 1'b0) begin bad++; $display("FAIL midrst_s_rready got=%b exp=0", s_rready); end
    total++; if ({s_araddr, s_arlen, s_slave_no} !== '0) begin bad++; $display("FAIL midrst_ar_fields got=%h exp=0", {s_araddr, s_arlen, s_slave_no}); end
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL midrst_state got=%0d exp=0", dbg_state); end
    s_rvalid = 1'b0;
    @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    @(posedge ACLK);
    #1;
    total++; if (exp0_q.size() != 0) begin bad++; $display("FAIL midrst_beats left=%0d exp=0", exp0_q.size()); end
    grant_log.delete();
    exp_ar_q.push_back({3'd0, 8'd0, 32'h0000_3000});
    push_beats(1, 1, 32'h1234_5678);
    fork
      master_req(1, 32'h0000_3000, 8'd0);
      slave_serve(0, 1, 32'h1234_5678);
    join
    @(posedge ACLK);
    #1;
    total++; if (grant_log.size() != 1 || grant_log[0] != 1) begin bad++; $display("FAIL post_rst_grant count=%0d exp=1 grant to m1", grant_log.size()); end
    total++; if (exp1_q.size() + exp_ar_q.size() != 0) begin bad++; $display("FAIL post_rst_txn left=%0d exp=0", exp1_q.size() + exp_ar_q.size()); end
    total++; if (timeouts != 0) begin bad++; $display("FAIL post_rst_timeout got=%0d exp=0", timeouts); end
  endtask

  task automatic test_random_singles();
    int idx;
    int len;
    logic [AW-1:0] addr;
    logic [DW-1:0] base;
    for (int k = 0; k < 4; k++) begin
      idx  = $urandom_range(0, 1);
      len  = $urandom_range(0, 4);
      addr = {4'($urandom_range(0, 4)), 4'($urandom_range(0, 3)), 24'($urandom)};
      base = 32'($urandom);
      exp_ar_q.push_back({(addr[31:28] == 4'd4) ? 3'd1 : 3'd0, 8'(len), addr});
      push_beats(idx, len + 1, base);
      fork
        master_req(idx, addr, 8'(len));
        slave_serve(int'($urandom_range(0, 3)), len + 1, base);
      join
    end
    @(posedge ACLK);
    #1;
    total++; if (exp0_q.size() + exp1_q.size() + exp_ar_q.size() != 0) begin bad++; $display("FAIL random_left got=%0d exp=0", exp0_q.size() + exp1_q.size() + exp_ar_q.size()); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    ARESET = 1'b1;
    m0_arvalid = 1'b0; m0_araddr = '0; m0_arlen = '0; m0_rready = 1'b1;
    m1_arvalid = 1'b0; m1_araddr = '0; m1_arlen = '0; m1_rready = 1'b1;
    s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_rresp = '0; s_rlast = 1'b0;
    @(posedge ACLK);
    #1;
    test_reset();
    test_single_m0();
    test_round_robin();
    test_backpressure();
    test_decerr();
    test_reset_mid();
    test_random_singles();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
